global_ale: RTL and testbench



---
 rtl/global_ale.sv | 136 +++++++++++++
 tb/tb_global_ale.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/global_ale.sv
// Frame-level global atmospheric light estimator: publishes RGB of the max dark-channel pixel.
// Define GLOBAL_ALE_IIR_EN to blend each new A with the previous one (3:1 temporal smoothing).
module global_ale #(
  parameter int          IMG_W     = 640,
  parameter int          IMG_H     = 480,
  parameter logic [7:0]  A_DEFAULT = 8'd255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       sof,
  input  logic [7:0] IDark,
  input  logic [7:0] R,
  input  logic [7:0] G,
  input  logic [7:0] B,
  output logic [7:0] AR_global,
  output logic [7:0] AG_global,
  output logic [7:0] AB_global,
  output logic       A_valid,
  output logic       sof_err
);

  localparam int FRAME_PIX = IMG_W * IMG_H;
  localparam int CW = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_PIX - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    PUBLISH
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    max_dark;
  logic [7:0]    cand_r;
  logic [7:0]    cand_g;
  logic [7:0]    cand_b;
  logic          accept;

  assign in_ready = (state != PUBLISH);
  assign accept   = in_valid & in_ready;

`ifdef GLOBAL_ALE_IIR_EN
  function automatic logic [7:0] blend(
    input logic [7:0] a_old,
    input logic [7:0] cand
  );
    logic [9:0] sum;
    sum = {2'b00, a_old} + {1'b0, a_old, 1'b0} + {2'b00, cand};
    return sum[9:2];
  endfunction
`else
  function automatic logic [7:0] blend(
    input logic [7:0] a_old,
    input logic [7:0] cand
  );
    logic [7:0] unused;
    unused = a_old;
    return cand;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      max_dark  <= '0;
      cand_r    <= '0;
      cand_g    <= '0;
      cand_b    <= '0;
      AR_global <= A_DEFAULT;
      AG_global <= A_DEFAULT;
      AB_global <= A_DEFAULT;
      A_valid   <= 1'b0;
      sof_err   <= 1'b0;
    end else begin
      A_valid <= 1'b0;
      sof_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept && sof) begin
            max_dark <= IDark;
            cand_r   <= R;
            cand_g   <= G;
            cand_b   <= B;
            if (FRAME_PIX == 1) begin
              cnt   <= '0;
              state <= PUBLISH;
            end else begin
              cnt   <= CNT_ONE;
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            if (sof) begin
              // restart: partial frame is abandoned, outputs untouched
              sof_err  <= 1'b1;
              max_dark <= IDark;
              cand_r   <= R;
              cand_g   <= G;
              cand_b   <= B;
              cnt      <= CNT_ONE;
            end else begin
              if (IDark > max_dark) begin
                max_dark <= IDark;
                cand_r   <= R;
                cand_g   <= G;
                cand_b   <= B;
              end
              if (cnt == CNT_LAST) begin
                cnt   <= '0;
                state <= PUBLISH;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end
          end
        end
        PUBLISH: begin
          AR_global <= blend(AR_global, cand_r);
          AG_global <= blend(AG_global, cand_g);
          AB_global <= blend(AB_global, cand_b);
          A_valid   <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_global_ale.sv
// Self-checking bench for global_ale with 4x2 frames.
// Reference model: first-maximum search over a frame array, optional 3:1 blend.
module tb_global_ale;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       sof = 1'b0;
  logic [7:0] IDark = '0;
  logic [7:0] R = '0;
  logic [7:0] G = '0;
  logic [7:0] B = '0;
  logic [7:0] AR_global;
  logic [7:0] AG_global;
  logic [7:0] AB_global;
  logic       A_valid;
  logic       sof_err;

  global_ale #(.IMG_W(4), .IMG_H(2), .A_DEFAULT(8'd255)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sof(sof), .IDark(IDark), .R(R), .G(G), .B(B),
    .AR_global(AR_global), .AG_global(AG_global), .AB_global(AB_global),
    .A_valid(A_valid), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int err_pulses = 0;
  int cap_r, cap_g, cap_b;
  int fd[8], fr[8], fg[8], fb[8];
  int a_m[3];

  always @(negedge clk) begin
    if (A_valid) begin
      pulses++;
      cap_r = AR_global;
      cap_g = AG_global;
      cap_b = AB_global;
    end
    if (sof_err) err_pulses++;
  end

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) a_m[k] = 255;
  endfunction

  function automatic void model_publish();
    int best;
    int c[3];
    best = 0;
    for (int i = 1; i < 8; i++)
      if (fd[i] > fd[best]) best = i;
    c[0] = fr[best];
    c[1] = fg[best];
    c[2] = fb[best];
    for (int k = 0; k < 3; k++) begin
`ifdef GLOBAL_ALE_IIR_EN
      a_m[k] = (3 * a_m[k] + c[k]) / 4;
`else
      a_m[k] = c[k];
`endif
    end
  endfunction

  function automatic int a_out();
    return {8'h0, AR_global, AG_global, AB_global};
  endfunction

  function automatic int a_exp();
    return (a_m[0] << 16) | (a_m[1] << 8) | a_m[2];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pixel(input int d, input int r, input int g,
                            input int b, input bit s, input int gap);
    bit acc;
    int n;
    repeat (gap) step();
    IDark = d[7:0];
    R = r[7:0];
    G = g[7:0];
    B = b[7:0];
    sof = s;
    in_valid = 1'b1;
    n = 0;
    do begin
      acc = in_ready;
      step();
      n++;
    end while (!acc && n < 20);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: pixel not accepted in %0d cycles", n);
    end
    in_valid = 1'b0;
    sof = 1'b0;
  endtask

  task automatic run_frame(input int gap);
    for (int i = 0; i < 8; i++)
      send_pixel(fd[i], fr[i], fg[i], fb[i], i == 0, gap);
  endtask

  task automatic spec_frame();
    int d[8];
    d = '{10, 50, 200, 30, 200, 5, 0, 7};
    for (int i = 0; i < 8; i++) begin
      fd[i] = d[i];
      fr[i] = i * 10;
      fg[i] = i * 10 + 1;
      fb[i] = i * 10 + 2;
    end
    fr[2] = 210; fg[2] = 220; fb[2] = 230;
    fr[4] = 1;   fg[4] = 2;   fb[4] = 3;
  endtask

  task automatic rand_frame(input int range);
    for (int i = 0; i < 8; i++) begin
      fd[i] = $urandom_range(0, range);
      fr[i] = $urandom_range(0, 255);
      fg[i] = $urandom_range(0, 255);
      fb[i] = $urandom_range(0, 255);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_reset();
    checks++;
    if (a_out() !== 32'h00ffffff) begin
      errors++;
      $display("FAIL reset_a: got %06h want ffffff", a_out());
    end
    checks++;
    if (A_valid !== 1'b0 || sof_err !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctl: A_valid=%b sof_err=%b in_ready=%b want 0 0 1",
               A_valid, sof_err, in_ready);
    end
  endtask

  task automatic test_no_sof();
    int p0;
    p0 = pulses;
    for (int i = 0; i < 10; i++)
      send_pixel($urandom_range(0, 255), 1, 2, 3, 1'b0, 0);
    repeat (3) step();
    checks++;
    if (pulses !== p0 || a_out() !== 32'h00ffffff) begin
      errors++;
      $display("FAIL no_sof: pulses %0d want %0d, A %06h want ffffff",
               pulses - p0, 0, a_out());
    end
  endtask

  task automatic test_spec_frame();
    int old_a;
    spec_frame();
    old_a = a_exp();
    run_frame(0);
    checks++;
    if (in_ready !== 1'b0 || A_valid !== 1'b0 || a_out() !== old_a) begin
      errors++;
      $display("FAIL publish_cycle: in_ready=%b A_valid=%b A=%06h want 0 0 %06h",
               in_ready, A_valid, a_out(), old_a);
    end
    model_publish();
    step();
    checks++;
    if (a_out() !== a_exp()) begin
      errors++;
      $display("FAIL spec_a: got %06h want %06h", a_out(), a_exp());
    end
`ifndef GLOBAL_ALE_IIR_EN
    checks++;
    if (a_out() !== 32'h00d2dce6) begin
      errors++;
      $display("FAIL spec_a_const: got %06h want d2dce6", a_out());
    end
`else
    checks++;
    if (a_out() !== 32'h00f3f6f8) begin
      errors++;
      $display("FAIL spec_a_iir: got %06h want f3f6f8", a_out());
    end
`endif
    checks++;
    if (A_valid !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL pulse_on: A_valid=%b in_ready=%b want 1 1", A_valid, in_ready);
    end
    step();
    checks++;
    if (A_valid !== 1'b0) begin
      errors++;
      $display("FAIL pulse_off: A_valid=%b want 0", A_valid);
    end
  endtask

  task automatic test_gaps();
    int p0;
    p0 = pulses;
    spec_frame();
    run_frame(1);
    model_publish();
    repeat (2) step();
    checks++;
    if (pulses - p0 !== 1 || a_out() !== a_exp()) begin
      errors++;
      $display("FAIL gaps: pulses %0d want 1, A %06h want %06h",
               pulses - p0, a_out(), a_exp());
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    int mid;
    p0 = pulses;
    rand_frame(255);
    run_frame(0);
    model_publish();
    mid = a_exp();
    rand_frame(255);
    run_frame(0);
    model_publish();
    repeat (2) step();
    checks++;
    if (pulses - p0 !== 2 || a_out() !== a_exp()) begin
      errors++;
      $display("FAIL back_to_back: pulses %0d want 2, A %06h want %06h (mid %06h)",
               pulses - p0, a_out(), a_exp(), mid);
    end
  endtask

  task automatic test_sof_err();
    int p0;
    int e0;
    p0 = pulses;
    e0 = err_pulses;
    for (int i = 0; i < 5; i++)
      send_pixel(i == 1 ? 250 : 3, 9, 9, 9, i == 0, 0);
    rand_frame(200);
    send_pixel(fd[0], fr[0], fg[0], fb[0], 1'b1, 0);
    checks++;
    if (sof_err !== 1'b1) begin
      errors++;
      $display("FAIL sof_err_on: got %b want 1", sof_err);
    end
    for (int i = 1; i < 7; i++)
      send_pixel(fd[i], fr[i], fg[i], fb[i], 1'b0, 0);
    step();
    checks++;
    if (pulses !== p0 || sof_err !== 1'b0) begin
      errors++;
      $display("FAIL sof_err_early: pulses %0d want 0, sof_err %b want 0",
               pulses - p0, sof_err);
    end
    send_pixel(fd[7], fr[7], fg[7], fb[7], 1'b0, 0);
    model_publish();
    repeat (2) step();
    checks++;
    if (pulses - p0 !== 1 || err_pulses - e0 !== 1 || a_out() !== a_exp()) begin
      errors++;
      $display("FAIL sof_err_frame: pulses %0d errs %0d want 1 1, A %06h want %06h",
               pulses - p0, err_pulses - e0, a_out(), a_exp());
    end
  endtask

  task automatic test_rst_mid();
    int p0;
    p0 = pulses;
    rand_frame(255);
    for (int i = 0; i < 6; i++)
      send_pixel(fd[i], fr[i], fg[i], fb[i], i == 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    checks++;
    if (a_out() !== 32'h00ffffff || A_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: A %06h A_valid %b in_ready %b want ffffff 0 1",
               a_out(), A_valid, in_ready);
    end
    send_pixel(fd[6], fr[6], fg[6], fb[6], 1'b0, 0);
    send_pixel(fd[7], fr[7], fg[7], fb[7], 1'b0, 0);
    repeat (3) step();
    checks++;
    if (pulses !== p0) begin
      errors++;
      $display("FAIL rst_mid_pulse: pulses %0d want 0", pulses - p0);
    end
    rand_frame(255);
    run_frame(0);
    model_publish();
    repeat (2) step();
    checks++;
    if (pulses - p0 !== 1 || a_out() !== a_exp()) begin
      errors++;
      $display("FAIL rst_mid_next: pulses %0d want 1, A %06h want %06h",
               pulses - p0, a_out(), a_exp());
    end
  endtask

  task automatic test_rst_publish();
    int p0;
    p0 = pulses;
    rand_frame(255);
    run_frame(0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    repeat (2) step();
    checks++;
    if (pulses !== p0 || a_out() !== 32'h00ffffff) begin
      errors++;
      $display("FAIL rst_publish: pulses %0d want 0, A %06h want ffffff",
               pulses - p0, a_out());
    end
  endtask

  task automatic test_random();
    int p0;
    for (int f = 0; f < 20; f++) begin
      p0 = pulses;
      rand_frame((f % 2 == 0) ? 7 : 255);
      run_frame($urandom_range(0, 2));
      model_publish();
      repeat (2) step();
      checks++;
      if (pulses - p0 !== 1 || a_out() !== a_exp() ||
          ((cap_r << 16) | (cap_g << 8) | cap_b) !== a_exp()) begin
        errors++;
        $display("FAIL random_%0d: pulses %0d want 1, A %06h want %06h",
                 f, pulses - p0, a_out(), a_exp());
      end
    end
  endtask

  initial begin
    test_reset();
    test_no_sof();
    test_spec_frame();
    test_gaps();
    test_back_to_back();
    test_sof_err();
    test_rst_mid();
    test_rst_publish();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
